// File: rtl/id_stage_if.sv
// Bundle of fetch, memory-read and execute handshake signals around the decode stage.
// The master modport is the decode stage's view; slave is the surrounding pipeline.
interface id_stage_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  localparam int INST_W = ADDR_W + 3;

  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] resreg;

  logic              rmem_req;
  logic [ADDR_W-1:0] rmemaddr;
  logic              rmem_ack;
  logic [DATA_W-1:0] rmem_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] val1;
  logic [DATA_W-1:0] val2;
  logic              wmem;
  logic [ADDR_W-1:0] wmemaddr;
  logic              wresreg;
  logic              wpc;
  logic [ADDR_W-1:0] pc_o;
  logic [ADDR_W-1:0] out_pc;
  logic              flush;

  modport master (
    input  inst_valid, inst, pc, resreg, rmem_ack, rmem_data, out_ready,
    output inst_ready, rmem_req, rmemaddr, out_valid, val1, val2, wmem, wmemaddr,
           wresreg, wpc, pc_o, out_pc, flush
  );

  modport slave (
    output inst_valid, inst, pc, resreg, rmem_ack, rmem_data, out_ready,
    input  inst_ready, rmem_req, rmemaddr, out_valid, val1, val2, wmem, wmemaddr,
           wresreg, wpc, pc_o, out_pc, flush
  );
endinterface

// File: rtl/id_stage.sv
// Single-slot instruction decode stage for the accumulator CPU: decodes, fetches memory
// operands, stalls on accumulator hazards and requests a fetch flush on jump handoff.
module id_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input logic        clk,
  input logic        reset_n,
  id_stage_if.master bus
);
  localparam int INST_W = ADDR_W + 3;

  typedef enum logic [1:0] {IDLE, MEM, HOLD} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] val1_q, val1_d, val2_q, val2_d;
  logic              wmem_q, wmem_d, wresreg_q, wresreg_d, wpc_q, wpc_d;
  logic [ADDR_W-1:0] wmemaddr_q, wmemaddr_d, pc_o_q, pc_o_d;
  logic [ADDR_W-1:0] rmemaddr_q, rmemaddr_d, out_pc_q, out_pc_d;

  logic [2:0]        op_s;
  logic [1:0]        op_l;
  logic [DATA_W-1:0] imm;
  logic [ADDR_W-1:0] addr;

  logic              dec_mem, dec_nop, dec_reads_acc;
  logic [DATA_W-1:0] dec_val1, dec_val2;
  logic              dec_wmem, dec_wresreg, dec_wpc;
  logic [ADDR_W-1:0] dec_wmemaddr, dec_pc_o, dec_rmemaddr;

  logic hazard, accept;

  assign op_s = bus.inst[INST_W-2 -: 3];
  assign op_l = bus.inst[INST_W-2 -: 2];
  assign imm  = DATA_W'(bus.inst[INST_W-5:0]);
  assign addr = bus.inst[ADDR_W-1:0];

  always_comb begin
    dec_mem       = 1'b0;
    dec_nop       = 1'b0;
    dec_reads_acc = 1'b0;
    dec_val1      = '0;
    dec_val2      = '0;
    dec_wmem      = 1'b0;
    dec_wresreg   = 1'b0;
    dec_wpc       = 1'b0;
    dec_wmemaddr  = '0;
    dec_pc_o      = '0;
    dec_rmemaddr  = '0;
    if (!bus.inst[INST_W-1]) begin
      case (op_s)
        3'b001: begin
          dec_val2    = imm;
          dec_wresreg = 1'b1;
        end
        3'b010: begin
          dec_val1      = bus.resreg;
          dec_val2      = imm;
          dec_wresreg   = 1'b1;
          dec_reads_acc = 1'b1;
        end
        default: dec_nop = 1'b1;
      endcase
    end else begin
      case (op_l)
        2'b00: begin
          dec_mem       = 1'b1;
          dec_val1      = bus.resreg;
          dec_wresreg   = 1'b1;
          dec_reads_acc = 1'b1;
          dec_rmemaddr  = addr;
        end
        2'b01: begin
          dec_mem      = 1'b1;
          dec_wresreg  = 1'b1;
          dec_rmemaddr = addr;
        end
        2'b10: begin
          dec_val2      = bus.resreg;
          dec_wmem      = 1'b1;
          dec_wmemaddr  = addr;
          dec_reads_acc = 1'b1;
        end
        default: begin
          dec_wpc  = 1'b1;
          dec_pc_o = addr;
        end
      endcase
    end
  end

  // A held accumulator writer blocks a reader until execute has committed it.
  assign hazard = (state_q == HOLD) && wresreg_q && bus.inst_valid && dec_reads_acc;
  assign accept = bus.inst_valid && bus.inst_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = dec_nop ? IDLE : (dec_mem ? MEM : HOLD);
      MEM:  if (bus.rmem_ack) state_d = HOLD;
      HOLD: begin
        if (accept)             state_d = dec_nop ? IDLE : (dec_mem ? MEM : HOLD);
        else if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid  = (state_q == HOLD);
    bus.rmem_req   = (state_q == MEM);
    bus.flush      = reset_n && (state_q == HOLD) && wpc_q && bus.out_ready;
    bus.inst_ready = 1'b0;
    if (reset_n) begin
      case (state_q)
        IDLE:    bus.inst_ready = 1'b1;
        HOLD:    bus.inst_ready = bus.out_ready && !wpc_q && !hazard;
        default: bus.inst_ready = 1'b0;
      endcase
    end
  end

  // Control bits clear on handoff so nothing stays asserted while the slot is empty.
  always_comb begin
    val1_d     = val1_q;
    val2_d     = val2_q;
    wmem_d     = wmem_q;
    wresreg_d  = wresreg_q;
    wpc_d      = wpc_q;
    wmemaddr_d = wmemaddr_q;
    pc_o_d     = pc_o_q;
    rmemaddr_d = rmemaddr_q;
    out_pc_d   = out_pc_q;
    if (accept) begin
      val1_d     = dec_val1;
      val2_d     = dec_val2;
      wmem_d     = dec_wmem;
      wresreg_d  = dec_wresreg;
      wpc_d      = dec_wpc;
      wmemaddr_d = dec_wmemaddr;
      pc_o_d     = dec_pc_o;
      rmemaddr_d = dec_rmemaddr;
      out_pc_d   = bus.pc;
    end else if (state_q == MEM && bus.rmem_ack) begin
      val2_d = bus.rmem_data;
    end else if (state_q == HOLD && bus.out_ready) begin
      wmem_d    = 1'b0;
      wresreg_d = 1'b0;
      wpc_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      val1_q     <= '0;
      val2_q     <= '0;
      wmem_q     <= 1'b0;
      wresreg_q  <= 1'b0;
      wpc_q      <= 1'b0;
      wmemaddr_q <= '0;
      pc_o_q     <= '0;
      rmemaddr_q <= '0;
      out_pc_q   <= '0;
    end else begin
      val1_q     <= val1_d;
      val2_q     <= val2_d;
      wmem_q     <= wmem_d;
      wresreg_q  <= wresreg_d;
      wpc_q      <= wpc_d;
      wmemaddr_q <= wmemaddr_d;
      pc_o_q     <= pc_o_d;
      rmemaddr_q <= rmemaddr_d;
      out_pc_q   <= out_pc_d;
    end
  end

  assign bus.val1     = val1_q;
  assign bus.val2     = val2_q;
  assign bus.wmem     = wmem_q;
  assign bus.wresreg  = wresreg_q;
  assign bus.wpc      = wpc_q;
  assign bus.wmemaddr = wmemaddr_q;
  assign bus.pc_o     = pc_o_q;
  assign bus.rmemaddr = rmemaddr_q;
  assign bus.out_pc   = out_pc_q;
endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, immediate ops, memory operand latency,
// hazard bubble, jump flush and reset during an output stall.
module tb_id_stage;
  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  id_stage_if #(.DATA_W(8), .ADDR_W(5)) bus ();

  id_stage #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [7:0] ins, input logic [4:0] pcv,
                                input logic ordy);
    bus.inst_valid = valid;
    bus.inst       = ins;
    bus.pc         = pcv;
    bus.out_ready  = ordy;
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check_output({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check_output({tag, "_rmem_req"},  32'(bus.rmem_req), 0);
    check_output({tag, "_flush"},     32'(bus.flush), 0);
    check_output({tag, "_wmem"},      32'(bus.wmem), 0);
    check_output({tag, "_wresreg"},   32'(bus.wresreg), 0);
    check_output({tag, "_wpc"},       32'(bus.wpc), 0);
    check_output({tag, "_val1"},      32'(bus.val1), 0);
    check_output({tag, "_val2"},      32'(bus.val2), 0);
    check_output({tag, "_wmemaddr"},  32'(bus.wmemaddr), 0);
    check_output({tag, "_pc_o"},      32'(bus.pc_o), 0);
    check_output({tag, "_rmemaddr"},  32'(bus.rmemaddr), 0);
    check_output({tag, "_out_pc"},    32'(bus.out_pc), 0);
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset_n        = 1'b0;
    bus.resreg     = 8'h00;
    bus.rmem_ack   = 1'b0;
    bus.rmem_data  = 8'h00;
    apply_stimulus(1'b1, 8'h15, 5'd0, 1'b1);

    $display("[TB] reset with instruction offered");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cleared("rst");
      check_output("rst_inst_ready", 32'(bus.inst_ready), 0);
    end
    reset_n = 1'b1;
    apply_stimulus(1'b0, 8'h15, 5'd0, 1'b1);
    check_output("rel_inst_ready", 32'(bus.inst_ready), 1);
    check_output("rel_out_valid", 32'(bus.out_valid), 0);
    tick();
    check_output("rel_out_valid2", 32'(bus.out_valid), 0);

    $display("[TB] loadi 0x15");
    apply_stimulus(1'b1, 8'h15, 5'd1, 1'b1);
    tick();
    apply_stimulus(1'b0, 8'h00, 5'd0, 1'b1);
    check_output("loadi_valid", 32'(bus.out_valid), 1);
    check_output("loadi_val1", 32'(bus.val1), 32'h00);
    check_output("loadi_val2", 32'(bus.val2), 32'h05);
    check_output("loadi_wresreg", 32'(bus.wresreg), 1);
    check_output("loadi_wmem", 32'(bus.wmem), 0);
    check_output("loadi_wpc", 32'(bus.wpc), 0);
    check_output("loadi_flush", 32'(bus.flush), 0);
    check_output("loadi_out_pc", 32'(bus.out_pc), 1);
    tick();
    bus.resreg = 8'h05;
    check_output("loadi_done", 32'(bus.out_valid), 0);

    $display("[TB] add 0x83 with three-cycle memory latency");
    bus.resreg = 8'h07;
    apply_stimulus(1'b1, 8'h83, 5'd2, 1'b1);
    tick();
    apply_stimulus(1'b0, 8'h00, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_output("add_rmem_req", 32'(bus.rmem_req), 1);
      check_output("add_rmemaddr", 32'(bus.rmemaddr), 3);
      check_output("add_inst_ready", 32'(bus.inst_ready), 0);
      check_output("add_out_valid", 32'(bus.out_valid), 0);
      if (i == 2) begin
        bus.rmem_ack  = 1'b1;
        bus.rmem_data = 8'h20;
      end
      tick();
    end
    bus.rmem_ack  = 1'b0;
    bus.rmem_data = 8'hFF;
    #1;
    check_output("add_valid", 32'(bus.out_valid), 1);
    check_output("add_val1", 32'(bus.val1), 32'h07);
    check_output("add_val2", 32'(bus.val2), 32'h20);
    check_output("add_wresreg", 32'(bus.wresreg), 1);
    check_output("add_req_drop", 32'(bus.rmem_req), 0);
    tick();
    bus.resreg = 8'h27;

    $display("[TB] stray acknowledge while idle");
    bus.rmem_ack  = 1'b1;
    bus.rmem_data = 8'h55;
    tick();
    bus.rmem_ack = 1'b0;
    #1;
    check_output("stray_valid", 32'(bus.out_valid), 0);
    check_output("stray_val2", 32'(bus.val2), 32'h20);
    check_output("stray_req", 32'(bus.rmem_req), 0);

    $display("[TB] loadi then dependent addi");
    apply_stimulus(1'b1, 8'h12, 5'd3, 1'b1);
    tick();
    apply_stimulus(1'b1, 8'h23, 5'd4, 1'b1);
    check_output("haz_valid", 32'(bus.out_valid), 1);
    check_output("haz_val2", 32'(bus.val2), 32'h02);
    check_output("haz_inst_ready", 32'(bus.inst_ready), 0);
    tick();
    bus.resreg = 8'h02;
    #1;
    check_output("haz_bubble", 32'(bus.out_valid), 0);
    check_output("haz_retry_ready", 32'(bus.inst_ready), 1);
    tick();
    apply_stimulus(1'b0, 8'h00, 5'd0, 1'b1);
    check_output("addi_valid", 32'(bus.out_valid), 1);
    check_output("addi_val1", 32'(bus.val1), 32'h02);
    check_output("addi_val2", 32'(bus.val2), 32'h03);
    check_output("addi_out_pc", 32'(bus.out_pc), 4);
    tick();
    bus.resreg = 8'h05;

    $display("[TB] independent loadi pair");
    apply_stimulus(1'b1, 8'h17, 5'd5, 1'b1);
    tick();
    apply_stimulus(1'b1, 8'h19, 5'd6, 1'b1);
    check_output("b2b_ready", 32'(bus.inst_ready), 1);
    check_output("b2b_first", 32'(bus.val2), 32'h07);
    tick();
    apply_stimulus(1'b0, 8'h00, 5'd0, 1'b1);
    check_output("b2b_valid", 32'(bus.out_valid), 1);
    check_output("b2b_second", 32'(bus.val2), 32'h09);
    tick();

    $display("[TB] jump with loadi offered behind it");
    apply_stimulus(1'b1, 8'hE9, 5'd7, 1'b1);
    tick();
    apply_stimulus(1'b1, 8'h11, 5'd8, 1'b1);
    check_output("jmp_valid", 32'(bus.out_valid), 1);
    check_output("jmp_wpc", 32'(bus.wpc), 1);
    check_output("jmp_pc_o", 32'(bus.pc_o), 9);
    check_output("jmp_wresreg", 32'(bus.wresreg), 0);
    check_output("jmp_flush", 32'(bus.flush), 1);
    check_output("jmp_inst_ready", 32'(bus.inst_ready), 0);
    tick();
    check_output("jmp_flush_gone", 32'(bus.flush), 0);
    check_output("jmp_after_valid", 32'(bus.out_valid), 0);
    check_output("jmp_after_ready", 32'(bus.inst_ready), 1);
    tick();
    apply_stimulus(1'b0, 8'h00, 5'd0, 1'b1);
    check_output("jmp_next_valid", 32'(bus.out_valid), 1);
    check_output("jmp_next_val2", 32'(bus.val2), 32'h01);
    tick();

    $display("[TB] stalled store then reset");
    bus.resreg = 8'hAB;
    apply_stimulus(1'b1, 8'hC4, 5'd9, 1'b0);
    tick();
    bus.resreg = 8'h00;
    apply_stimulus(1'b1, 8'h15, 5'd10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_output("st_valid", 32'(bus.out_valid), 1);
      check_output("st_wmem", 32'(bus.wmem), 1);
      check_output("st_wmemaddr", 32'(bus.wmemaddr), 4);
      check_output("st_val2", 32'(bus.val2), 32'hAB);
      check_output("st_inst_ready", 32'(bus.inst_ready), 0);
      tick();
      #1;
    end
    reset_n = 1'b0;
    tick();
    check_cleared("st_rst");
    check_output("st_rst_ready", 32'(bus.inst_ready), 0);
    reset_n = 1'b1;
    apply_stimulus(1'b0, 8'h00, 5'd0, 1'b1);
    tick();
    check_output("st_post_valid", 32'(bus.out_valid), 0);
    check_output("st_post_wmem", 32'(bus.wmem), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
